// File: rtl/stream_mux_pkg.sv
// ============================================================================
// stream_mux_pkg : shared mode encodings and channel-index helper
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index following idx in a ring of n channels.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotate-priority encoder starting at base
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    base,
  output logic                gnt_vld,
  output logic [SEL_W-1:0]    gnt_idx
);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [SEL_W-1:0]      off;
  logic [SEL_W:0]        sum;

  assign dbl = {req, req};
  // Rotating the doubled vector puts channel base at bit 0.
  assign rot = CHANNELS'(dbl >> base);

  always_comb begin
    gnt_vld = |req;
    off     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (SEL_W + 1)'(CHANNELS)) sum = sum - (SEL_W + 1)'(CHANNELS);
    gnt_idx = sum[SEL_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/stream_mux.sv
// ============================================================================
// stream_mux : N-channel registered mux, fixed-select or round-robin, valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  logic             space;
  logic             load;
  logic             fix_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .base    (ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // An out-of-range sel matches no channel, so it simply yields no grant.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) fix_vld = in_valid[i];
    end
  end

  assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign space   = !out_valid | out_ready;
  assign load    = space & gnt_vld;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
    assign in_ready[i] = rst_n & load & (gnt_idx == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= gnt_idx;
      ptr       <= SEL_W'(wrap_inc(int'(gnt_idx), CHANNELS));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// tb_stream_mux : directed self-checking bench for stream_mux (4 ch, 32 bit)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH*CHANNELS-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;

  int passed = 0;
  int total  = 0;

  stream_mux #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                         input logic [SEL_W-1:0] c);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_chan"},  64'(out_chan),  64'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < CHANNELS; i++) set_data(i, 32'hD000_0000 + 32'(i));

    // Reset holds everything idle even with every channel requesting
    tick;
    tick;
    chk_out("reset", 1'b0, 32'h0, 3'd0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);

    // Release in round-robin: channel 0 first, then 1,2,3,0,1 back to back
    rst_n = 1'b1;
    #1;
    chk("rr_first_ready", 64'(in_ready), 64'h1);
    tick;
    chk_out("rr0", 1'b1, 32'hD000_0000, 3'd0);
    tick;
    chk_out("rr1", 1'b1, 32'hD000_0001, 3'd1);
    tick;
    chk_out("rr2", 1'b1, 32'hD000_0002, 3'd2);
    tick;
    chk_out("rr3", 1'b1, 32'hD000_0003, 3'd3);
    tick;
    chk_out("rr4", 1'b1, 32'hD000_0000, 3'd0);
    tick;
    chk_out("rr5", 1'b1, 32'hD000_0001, 3'd1);

    // Fixed mode, sel=2
    mode     = 1'b0;
    sel      = 3'd2;
    in_valid = 4'b0100;
    set_data(2, 32'hA5A5_0002);
    #1;
    chk("fix2_ready", 64'(in_ready), 64'b0100);
    tick;
    chk_out("fix2", 1'b1, 32'hA5A5_0002, 3'd2);

    // Back-pressure: word held, channel 1 waiting
    out_ready = 1'b0;
    sel       = 3'd1;
    in_valid  = 4'b0010;
    set_data(1, 32'h1111_0001);
    #1;
    chk("stall0_ready", 64'(in_ready), 64'h0);
    tick;
    chk("stall1_ready", 64'(in_ready), 64'h0);
    chk_out("stall1", 1'b1, 32'hA5A5_0002, 3'd2);
    tick;
    chk("stall2_ready", 64'(in_ready), 64'h0);
    chk_out("stall2", 1'b1, 32'hA5A5_0002, 3'd2);
    tick;
    chk_out("stall3", 1'b1, 32'hA5A5_0002, 3'd2);

    // Drain and load in the same cycle
    out_ready = 1'b1;
    #1;
    chk("drain_ready", 64'(in_ready), 64'b0010);
    tick;
    chk_out("drain_load", 1'b1, 32'h1111_0001, 3'd1);

    // Serve channel 3 so the pointer wraps to 0
    sel      = 3'd3;
    in_valid = 4'b1000;
    set_data(3, 32'h3333_0003);
    tick;
    chk_out("fix3", 1'b1, 32'h3333_0003, 3'd3);

    // Out-of-range select grants nothing
    sel      = 3'd5;
    in_valid = 4'hF;
    #1;
    chk("oor_ready0", 64'(in_ready), 64'h0);
    tick;
    chk_out("oor_drain", 1'b0, 32'h3333_0003, 3'd3);
    chk("oor_ready1", 64'(in_ready), 64'h0);
    tick;
    chk("oor_idle_valid", 64'(out_valid), 64'h0);

    // Switch to round-robin from ptr=0
    mode = 1'b1;
    #1;
    chk("sw_rr_ready", 64'(in_ready), 64'h1);
    tick;
    chk_out("sw_rr", 1'b1, 32'hD000_0000, 3'd0);

    // Stall then asynchronous reset mid-cycle
    out_ready = 1'b0;
    #1;
    chk("pre_rst_ready", 64'(in_ready), 64'h0);
    tick;
    chk("pre_rst_valid", 64'(out_valid), 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 3'd0);
    chk("async_rst_ready", 64'(in_ready), 64'h0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    tick;
    chk_out("post_rst", 1'b1, 32'hD000_0000, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It selects one input per cycle, either by an explicit select index or by round-robin arbitration among requesting channels, and captures the chosen word in a single output register. It is the pipelined successor to the plain 2:1 datapath mux. It sits between producer stages, such as writeback sources or bus masters, and a single consumer that can stall.

## Interface
Parameters:
- WIDTH, default 32: data width per channel.
- CHANNELS, default 4, minimum 2: number of input channels.
- SEL_W, default $clog2(CHANNELS): select and channel-index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- mode  in  1  0 = fixed (use sel), 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_valid  in  CHANNELS  per-channel request.
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- in_data  in  WIDTH*CHANNELS  channel i occupies [i*WIDTH +: WIDTH].
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  SEL_W  index of the channel that supplied out_data.

## Operation
- Reset state:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=0.
  - in_ready is all-zero while rst_n=0.
- Space signal: space = !out_valid | out_ready. This is a bypass, so full throughput is achieved without a skid buffer.
- Grant, combinational, producing gnt_vld and gnt_idx:
  - Fixed mode: gnt_idx=sel and gnt_vld=in_valid[sel]. If sel >= CHANNELS, gnt_vld=0 (no grant, no error).
  - Round-robin mode: gnt_idx is the first i with in_valid[i]=1, scanning ptr, ptr+1, … modulo CHANNELS. gnt_vld = |in_valid.
- Ready and load:
  - in_ready[i] = space & gnt_vld & (gnt_idx==i).
  - load = space & gnt_vld.
- On load, at the clock edge:
  - out_data <= in_data[gnt_idx], out_chan <= gnt_idx, out_valid <= 1.
  - ptr <= (gnt_idx==CHANNELS-1) ? 0 : gnt_idx+1.
  - ptr advances in both modes, so a switch to round-robin starts after the last served channel.
- Else, if out_ready: out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid & !out_ready): out_data, out_chan and ptr hold; all in_ready are 0.
- mode and sel are sampled every cycle. A change affects only the grant for that cycle; no transfer already in the register is disturbed.
- A transfer occurs on an input when in_valid[i] & in_ready[i]. It occurs on the output when out_valid & out_ready.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle with out_ready held high.
- Simultaneous output drain and new load in the same cycle: the load wins, so out_valid stays 1 and the new word appears.
- Input protocol: in_ready may depend on in_valid. Producers must hold in_valid and in_data stable until accepted. The block does not check this.
- Round-robin fairness: with all channels valid and no stalls, the grant order is 0,1,…,CHANNELS-1,0,…. No channel waits more than CHANNELS-1 grants.
- Reset asserted mid-stall: the word in the output register is discarded; out_valid drops immediately and asynchronously.
- Reset release: the first grant can occur on the first rising edge with rst_n=1.

## Structure
- Shared package stream_mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - A function computing the wrap-increment of a channel index.
- Sub-module rr_pick (parameter CHANNELS):
  - Inputs: req[CHANNELS] and base[SEL_W].
  - Outputs: gnt_vld and gnt_idx.
  - Purely combinational rotate-priority encoder, implemented as a double-width request vector plus a priority scan.
- Top level holds the fixed/round-robin grant mux, the output register, ptr, and the ready decode.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0. Release -> the first word is from channel 0 in round-robin mode.
- Fixed mode, sel=2, CHANNELS=4, channel 2 sends 0xA5A5_0002 with out_ready=1 -> the next cycle shows out_valid=1, out_data=0xA5A5_0002, out_chan=2. Only in_ready[2] ever pulses.
- Round-robin, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with one word per cycle and no bubbles.
- Back-pressure: out_ready=0 for 3 cycles with a word held -> out_data is stable and in_ready=0. Then out_ready=1 with channel 1 valid -> drain and load occur in the same cycle, and out_valid never drops.
- Fixed mode with sel=5 and CHANNELS=4 (SEL_W=3), all channels valid -> no in_ready and out_valid stays 0. Then switch to mode=1 with ptr=0 -> channel 0 is granted next.
- Async reset asserted mid-stall with out_valid=1 -> out_valid=0 before the next clock edge, and ptr returns to 0.
